// File: rtl/playback_buffer_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | playback_buffer_ctrl                                             |
// | Ping-pong fill controller feeding the I2S two-half sample buffer |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module playback_buffer_ctrl #(
  parameter int ADDR_BITS = 9,
  parameter int DATA_W    = 16
) (
  input  logic                 master_clock,
  input  logic                 reset,
  input  logic                 enable_i,
  output logic                 src_req_o,
  input  logic                 src_ack_i,
  input  logic [DATA_W-1:0]    src_data_i,
  input  logic                 src_eof_i,
  output logic                 wr_en_o,
  output logic                 wr_buf_o,
  output logic [ADDR_BITS-1:0] wr_addr_o,
  output logic [DATA_W-1:0]    wr_data_o,
  input  logic                 buffer_empty_i,
  input  logic                 buffer_sel_i,
  output logic                 buffer_filled_o,
  output logic                 underrun_o,
  output logic                 busy_o,
  output logic                 done_o
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_WRITE  = 3'd2,
    ST_PAD    = 3'd3,
    ST_CHECK  = 3'd4,
    ST_FINISH = 3'd5
  } state_e;

  localparam logic [ADDR_BITS-1:0] LAST_ADDR = '1;

  state_e                 state_q, state_d;
  logic [1:0]             full_q, full_d;
  logic                   fill_buf_q, fill_buf_d;
  logic [ADDR_BITS-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]      data_q, data_d;
  logic                   eof_q, eof_d;
  logic                   underrun_q, underrun_d;
  logic                   filled_q, filled_d;
  logic                   done_q, done_d;
  logic                   e_meta_q, e_meta_d, e_s_q, e_s_d, e_prev_q, e_prev_d;
  logic                   s_meta_q, s_meta_d, s_s_q, s_s_d;
  logic                   en_prev_q, en_prev_d;

  logic                   drain;
  logic                   filling;
  logic                   set_full;

  always_comb begin
    state_d    = state_q;
    full_d     = full_q;
    fill_buf_d = fill_buf_q;
    wr_addr_d  = wr_addr_q;
    data_d     = data_q;
    eof_d      = eof_q;
    underrun_d = underrun_q;
    done_d     = 1'b0;
    e_meta_d   = buffer_empty_i;
    e_s_d      = e_meta_q;
    e_prev_d   = e_s_q;
    s_meta_d   = buffer_sel_i;
    s_s_d      = s_meta_q;
    en_prev_d  = enable_i;
    filled_d   = full_q[s_s_q];
    src_req_o  = 1'b0;
    wr_en_o    = 1'b0;
    wr_data_o  = data_q;

    drain    = e_s_q & ~e_prev_q;
    filling  = (state_q == ST_REQ) || (state_q == ST_WRITE) ||
               (state_q == ST_PAD) || (state_q == ST_CHECK);
    set_full = ((state_q == ST_WRITE) || (state_q == ST_PAD)) && (wr_addr_q == LAST_ADDR);

    // The transmitter has just moved on to s_s, so the other half is the one drained.
    if (drain) full_d[~s_s_q] = 1'b0;

    // Drains after end-of-file (FINISH) are the expected wind-down, not starvation.
    if (drain && enable_i && filling &&
        (!full_q[s_s_q] || (set_full && (fill_buf_q == ~s_s_q))))
      underrun_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        full_d     = 2'b00;
        fill_buf_d = 1'b0;
        wr_addr_d  = '0;
        eof_d      = 1'b0;
        if (enable_i && !en_prev_q) begin
          underrun_d = 1'b0;
          state_d    = ST_REQ;
        end
      end
      ST_REQ: begin
        src_req_o = 1'b1;
        if (src_ack_i) begin
          data_d  = src_data_i;
          eof_d   = src_eof_i;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        wr_en_o = 1'b1;
        if (wr_addr_q == LAST_ADDR) begin
          full_d[fill_buf_q] = 1'b1;
          fill_buf_d         = ~fill_buf_q;
          wr_addr_d          = '0;
          state_d            = ST_CHECK;
        end else if (eof_q) begin
          wr_addr_d = wr_addr_q + 1'b1;
          state_d   = ST_PAD;
        end else begin
          wr_addr_d = wr_addr_q + 1'b1;
          state_d   = enable_i ? ST_REQ : ST_CHECK;
        end
      end
      ST_PAD: begin
        wr_en_o   = 1'b1;
        wr_data_o = '0;
        if (wr_addr_q == LAST_ADDR) begin
          full_d[fill_buf_q] = 1'b1;
          fill_buf_d         = ~fill_buf_q;
          wr_addr_d          = '0;
          state_d            = ST_FINISH;
        end else begin
          wr_addr_d = wr_addr_q + 1'b1;
        end
      end
      ST_CHECK: begin
        if (!enable_i)                state_d = ST_FINISH;
        else if (!full_q[fill_buf_q]) state_d = ST_REQ;
      end
      ST_FINISH: begin
        if (full_q == 2'b00) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge master_clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      full_q     <= 2'b00;
      fill_buf_q <= 1'b0;
      wr_addr_q  <= '0;
      data_q     <= '0;
      eof_q      <= 1'b0;
      underrun_q <= 1'b0;
      filled_q   <= 1'b0;
      done_q     <= 1'b0;
      e_meta_q   <= 1'b0;
      e_s_q      <= 1'b0;
      e_prev_q   <= 1'b0;
      s_meta_q   <= 1'b0;
      s_s_q      <= 1'b0;
      en_prev_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      full_q     <= full_d;
      fill_buf_q <= fill_buf_d;
      wr_addr_q  <= wr_addr_d;
      data_q     <= data_d;
      eof_q      <= eof_d;
      underrun_q <= underrun_d;
      filled_q   <= filled_d;
      done_q     <= done_d;
      e_meta_q   <= e_meta_d;
      e_s_q      <= e_s_d;
      e_prev_q   <= e_prev_d;
      s_meta_q   <= s_meta_d;
      s_s_q      <= s_s_d;
      en_prev_q  <= en_prev_d;
    end
  end

  assign wr_buf_o        = fill_buf_q;
  assign wr_addr_o       = wr_addr_q;
  assign buffer_filled_o = filled_q;
  assign underrun_o      = underrun_q;
  assign busy_o          = (state_q != ST_IDLE);
  assign done_o          = done_q;

endmodule
`default_nettype wire

// File: tb/tb_playback_buffer_ctrl.sv
`default_nettype none
// tb_playback_buffer_ctrl: random-data source, write-order scoreboard and
// directed transmitter drain steps for playback_buffer_ctrl (ADDR_BITS=3).
module tb_playback_buffer_ctrl;
  localparam int AB   = 3;
  localparam int DW   = 16;
  localparam int HALF = 1 << AB;

  logic          master_clock, reset, enable_i;
  logic          src_req_o, src_ack_i, src_eof_i;
  logic [DW-1:0] src_data_i;
  logic          wr_en_o, wr_buf_o;
  logic [AB-1:0] wr_addr_o;
  logic [DW-1:0] wr_data_o;
  logic          buffer_empty_i, buffer_sel_i, buffer_filled_o;
  logic          underrun_o, busy_o, done_o;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int w_n, word_n, eof_index, pad_end, done_cnt, ack_min, ack_max;
  logic [DW:0] src_q[$];
  bit model_full[2];

  playback_buffer_ctrl #(.ADDR_BITS(AB), .DATA_W(DW)) dut (
    .master_clock    (master_clock),
    .reset           (reset),
    .enable_i        (enable_i),
    .src_req_o       (src_req_o),
    .src_ack_i       (src_ack_i),
    .src_data_i      (src_data_i),
    .src_eof_i       (src_eof_i),
    .wr_en_o         (wr_en_o),
    .wr_buf_o        (wr_buf_o),
    .wr_addr_o       (wr_addr_o),
    .wr_data_o       (wr_data_o),
    .buffer_empty_i  (buffer_empty_i),
    .buffer_sel_i    (buffer_sel_i),
    .buffer_filled_o (buffer_filled_o),
    .underrun_o      (underrun_o),
    .busy_o          (busy_o),
    .done_o          (done_o)
  );

  initial begin
    master_clock = 1'b0;
    forever #5 master_clock = ~master_clock;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge master_clock);
  endtask

  task automatic model_reset();
    src_q.delete();
    w_n = 0; word_n = 0; eof_index = -1; pad_end = 0; done_cnt = 0;
    model_full[0] = 1'b0; model_full[1] = 1'b0;
  endtask

  // Transmitter finished a half and now reads new_sel; the other half is drained.
  task automatic drain(input logic new_sel);
    buffer_sel_i   = new_sel;
    buffer_empty_i = 1'b1;
    model_full[~new_sel] = 1'b0;
    ticks(2);
    buffer_empty_i = 1'b0;
  endtask

  task automatic wait_writes(input string tag, input int n, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge master_clock);
      if (w_n >= n) ok = 1'b1;
    end
    check(tag, ok, 1);
  endtask

  // Scoreboard: the n-th write of a playback lands at half (n/HALF)%2, addr n%HALF,
  // carrying the n-th source word, or zero up to the end of the half holding EOF.
  always @(negedge master_clock) begin
    logic          ok;
    logic [DW-1:0] exp_d;
    logic [DW:0]   e;
    if (wr_en_o) begin
      ok = 1'b1;
      exp_d = '0;
      if (src_q.size() > 0) begin
        e = src_q.pop_front();
        exp_d = e[DW-1:0];
        if (e[DW]) pad_end = ((w_n / HALF) + 1) * HALF;
      end else if (w_n >= pad_end) begin
        ok = 1'b0;
      end
      check("wr_expected", ok, 1);
      check("wr_buf", wr_buf_o, (w_n / HALF) % 2);
      check("wr_addr", wr_addr_o, w_n % HALF);
      check("wr_data", wr_data_o, exp_d);
      if ((w_n % HALF) == HALF - 1) model_full[(w_n / HALF) % 2] = 1'b1;
      w_n++;
    end
    if (done_o) begin
      done_cnt++;
      check("busy_at_done", busy_o, 0);
    end
  end

  // Source: acks a pending request after a random delay with random data.
  initial begin : source
    int wait_cnt, cur_delay;
    wait_cnt = 0; cur_delay = 0;
    src_ack_i = 1'b0; src_eof_i = 1'b0; src_data_i = '0;
    forever begin
      @(negedge master_clock);
      src_ack_i = 1'b0;
      src_eof_i = 1'b0;
      if (reset || !src_req_o) begin
        wait_cnt = 0;
      end else begin
        if (wait_cnt == 0) cur_delay = $urandom_range(ack_max, ack_min);
        if (wait_cnt >= cur_delay) begin
          src_ack_i  = 1'b1;
          src_data_i = 16'($urandom);
          src_eof_i  = (word_n == eof_index);
          src_q.push_back({src_eof_i, src_data_i});
          word_n++;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  initial begin : main
    int  cyc, bad;
    bit  seen;
    reset = 1'b1; enable_i = 1'b0; buffer_empty_i = 1'b0; buffer_sel_i = 1'b0;
    ack_min = 0; ack_max = 0;
    model_reset();
    ticks(3);
    check("reset_outputs", {src_req_o, wr_en_o, wr_buf_o, wr_addr_o, wr_data_o,
                            buffer_filled_o, underrun_o, busy_o, done_o}, 0);
    reset = 1'b0;
    ticks(2);

    // Fill both halves with an immediate-ack source, transmitter idle.
    enable_i = 1'b1;
    ticks(1);
    check("req_after_enable", src_req_o, 1);
    check("busy_after_enable", busy_o, 1);
    wait_writes("fill_both_halves", 16, 200);
    ticks(6);
    check("writes_stop_at_16", w_n, 16);
    check("check_wait_no_req", src_req_o, 0);
    check("check_wait_busy", busy_o, 1);
    check("filled_sel0", buffer_filled_o, model_full[buffer_sel_i]);

    // Half 0 drained: refill request must appear 4 cycles after the empty edge.
    buffer_sel_i = 1'b1; buffer_empty_i = 1'b1; model_full[0] = 1'b0;
    cyc = 0; seen = 1'b0;
    for (int i = 1; i <= 10 && !seen; i++) begin
      @(negedge master_clock);
      if (i == 2) buffer_empty_i = 1'b0;
      if (src_req_o) begin seen = 1'b1; cyc = i; end
    end
    check("refill_latency", cyc, 4);
    wait_writes("refill_half0", 24, 200);
    ticks(6);
    check("writes_stop_at_24", w_n, 24);
    check("no_underrun_refill", underrun_o, 0);
    check("filled_sel1", buffer_filled_o, model_full[buffer_sel_i]);

    // EOF on the third word of half 1, then the two final drains.
    eof_index = 26;
    drain(1'b0);
    wait_writes("eof_half1", 32, 200);
    ticks(6);
    check("pad_total", w_n, 32);
    check("finish_no_req", src_req_o, 0);
    check("finish_busy", busy_o, 1);
    check("no_early_done", done_cnt, 0);
    drain(1'b1);
    ticks(8);
    check("done_waits_full", done_cnt, 0);
    check("filled_after_drain", buffer_filled_o, model_full[buffer_sel_i]);
    drain(1'b0);
    ticks(8);
    check("done_once", done_cnt, 1);
    check("idle_after_done", busy_o, 0);
    check("no_underrun_eof", underrun_o, 0);

    // Stalled source, then a drain while the transmitter's next half is empty.
    enable_i = 1'b0;
    ticks(2);
    model_reset();
    ack_min = 20; ack_max = 20;
    enable_i = 1'b1;
    ticks(1);
    check("underrun_clear_start", underrun_o, 0);
    check("stall_req_start", src_req_o, 1);
    bad = 0;
    for (int i = 0; i < 19; i++) begin
      @(negedge master_clock);
      if (!src_req_o || wr_en_o) bad++;
    end
    check("stall_req_held", bad, 0);
    wait_writes("stall_word", 1, 10);
    ack_min = 2; ack_max = 4;
    drain(1'b1);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (underrun_o) seen = 1'b1;
      else @(negedge master_clock);
    end
    check("underrun_set", seen, 1);

    // Stop after the fifth word of half 0.
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge master_clock);
      if (wr_en_o && wr_addr_o == 3'd4) seen = 1'b1;
    end
    check("reach_word5", seen, 1);
    enable_i = 1'b0;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge master_clock);
      if (src_req_o) bad++;
    end
    check("stop_no_req", bad, 0);
    check("stop_writes", w_n, 5);
    check("stop_done_once", done_cnt, 1);
    check("stop_idle", busy_o, 0);
    check("underrun_sticky", underrun_o, 1);

    // Restart clears underrun; reset while in REQ.
    model_reset();
    ack_min = 10; ack_max = 10;
    enable_i = 1'b1;
    ticks(1);
    check("underrun_cleared", underrun_o, 0);
    check("restart_req", src_req_o, 1);
    ticks(3);
    reset = 1'b1; enable_i = 1'b0;
    ticks(1);
    check("reset_mid_req", {src_req_o, wr_en_o, wr_buf_o, wr_addr_o, wr_data_o,
                            buffer_filled_o, underrun_o, busy_o, done_o}, 0);
    reset = 1'b0;
    model_reset();
    ticks(2);

    // Reset while padding.
    ack_min = 0; ack_max = 0; eof_index = 1;
    enable_i = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge master_clock);
      if (wr_en_o && wr_addr_o == 3'd4) seen = 1'b1;
    end
    check("reach_pad", seen, 1);
    reset = 1'b1; enable_i = 1'b0;
    ticks(1);
    check("reset_mid_pad", {src_req_o, wr_en_o, wr_buf_o, wr_addr_o, wr_data_o,
                            buffer_filled_o, underrun_o, busy_o, done_o}, 0);
    reset = 1'b0;
    model_reset();
    ticks(4);
    check("no_write_after_reset", w_n, 0);

    // New start after reset resumes at half 0, address 0.
    ack_min = 0; ack_max = 3;
    enable_i = 1'b1;
    wait_writes("restart_fill", 3, 60);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/playback_buffer_ctrl.md
# playback_buffer_ctrl

Ping-pong fill controller between the sample source (SD/file reader) and the I2S transmitter's two-half sample buffer. It pulls 16-bit words from the source over a req/ack handshake and writes them into whichever buffer half is free. It tracks the full/drained state of both halves and drives the transmitter's `buffer_filled` input. It also zero-pads at end of file, reports underruns, and signals end of playback once both halves have drained.

## Interface
- `ADDR_BITS`, 9: words per buffer half = 2^ADDR_BITS; equals the transmitter's buffer address width.
- `DATA_W`, 16: sample word width.

- `master_clock`  in  1  system clock, sole clock.
- `reset`  in  1  synchronous, active-high reset.
- `enable_i`  in  1  level; rising edge starts playback, low requests stop.
- `src_req_o`  out  1  request next word from source.
- `src_ack_i`  in  1  source word valid; `src_data_i` captured this cycle.
- `src_data_i`  in  DATA_W  source word.
- `src_eof_i`  in  1  sampled with `src_ack_i`; marks the last valid word.
- `wr_en_o`  out  1  buffer RAM write strobe.
- `wr_buf_o`  out  1  buffer half being written.
- `wr_addr_o`  out  ADDR_BITS  word address within half.
- `wr_data_o`  out  DATA_W  write data.
- `buffer_empty_i`  in  1  transmitter "half drained" flag.
- `buffer_sel_i`  in  1  half the transmitter reads next.
- `buffer_filled_o`  out  1  to transmitter: half `buffer_sel_i` is full.
- `underrun_o`  out  1  sticky underrun flag.
- `busy_o`  out  1  high in any state except IDLE.
- `done_o`  out  1  one-cycle pulse at end of playback.

## Operation
- `buffer_empty_i` and `buffer_sel_i` pass through 2-flop synchronizers (`e_s`, `s_s`).
- A drain event is a rising edge of `e_s`. The drained half is `~s_s`. On a drain event, `full[~s_s]` is cleared.
- `buffer_filled_o` = `full[s_s]`, registered.
- State machine:
  - IDLE: `full`=00, `fill_buf`=0, `wr_addr`=0. A rising edge of `enable_i` clears `underrun_o` and moves to REQ.
  - REQ: `src_req_o`=1 until `src_ack_i`. On ack, capture data and eof, then go to WRITE.
  - WRITE: `wr_en_o`=1 for one cycle at `{fill_buf, wr_addr}`.
    - If `wr_addr` = 2^ADDR_BITS−1: set `full[fill_buf]`, toggle `fill_buf`, `wr_addr`←0, go to CHECK.
    - Else if eof was captured: `wr_addr`+1, go to PAD.
    - Else: `wr_addr`+1, go to REQ (or CHECK if `enable_i`=0).
  - PAD: write 0 each cycle until the half is complete. Then set full, toggle `fill_buf`, go to FINISH.
  - CHECK: `enable_i`=0 → FINISH. `full[fill_buf]`=1 → stay (wait for drain). Otherwise → REQ.
  - FINISH: no requests issued. When `full`=00, pulse `done_o` and go to IDLE.
- `wr_addr` wraps only through the explicit reset to 0 at half completion. It never increments past 2^ADDR_BITS−1.
- Underrun: a drain event while `enable_i`=1 and `full[s_s]`=0 (transmitter's next half not ready) sets `underrun_o`. Filling continues normally.
- Simultaneous drain-clear and fill-set on the same half: the set wins, and `underrun_o` is set.
- Simultaneous drain event and half completion on different halves: both updates apply in the same cycle.
- A stop (`enable_i` low) mid-half leaves that half partially written and not marked full.
- `reset` asserted in any state takes effect at the next edge. No further write is issued.

## Timing
- Reset values: all outputs 0, `full`=00, `fill_buf`=0, `wr_addr`=0, state IDLE.
- `enable_i` rise at cycle t → `src_req_o` high at t+1.
- `src_ack_i` at cycle t → `wr_en_o` at t+1 with the captured data → next `src_req_o` at t+2. Minimum is 2 cycles per word.
- `src_req_o` drops in the cycle after ack. The source must not ack when req is low.
- Drain edge on `buffer_empty_i` → `full` bit cleared 3 cycles later → `buffer_filled_o` updated 4 cycles later.
- Full-bit set in WRITE/PAD at cycle t → `buffer_filled_o` high at t+1 if that half is selected.
- `done_o` is a single-cycle pulse, and `busy_o` falls in the same cycle.

## Test plan
- ADDR_BITS=3, source acks immediately, transmitter idle → 8 writes to half 0 (addr 0–7), then 8 to half 1. `full`=11, controller waits in CHECK, `buffer_filled_o`=1 with sel=0.
- Then toggle sel to 1 with an empty pulse → half 0 refilled with the next 8 words starting 4 cycles after the edge. `underrun_o` stays 0.
- EOF on word 3 of half 1 → words 3..7 written as 0x0000. After two drain events, `done_o` pulses once and `busy_o`=0.
- Source withholds ack for 20 cycles → `src_req_o` held for 20 cycles, `wr_en_o` low. A drain arrives with the next half not full → `underrun_o`=1 and stays set until the next `enable_i` rise.
- `enable_i` dropped after word 5 of half 0 → no further `src_req_o`. FINISH reached, `done_o` fires only after `full`=00.
- `reset` pulsed mid-REQ and mid-PAD → next cycle all outputs 0, and a new `enable_i` rise restarts at half 0, addr 0.
